ysyx_220053_mem_arb: RTL and testbench

//  Shares the single pmem port (DPI pmem_read/pmem_write wrapper) between IFU fetch and LSU load/store.

---
 rtl/ysyx_220053_pkg.sv | 11 +
 rtl/ysyx_220053_arb_pick.sv | 32 +++
 rtl/ysyx_220053_mem_arb.sv | 100 ++++++++++
 tb/tb_ysyx_220053_mem_arb.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ysyx_220053_pkg.sv
// ysyx_220053_pkg: shared types and constants for the pmem arbiter
package ysyx_220053_pkg;
  localparam int XLEN = 64;
  localparam int MASKW = 8;
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} arb_state_t;
  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;
  function automatic logic lsu_wins(input logic ls_v, input logic if_v, input logic at_limit);
    return ls_v & !(at_limit & if_v);
  endfunction
endpackage

// File: rtl/ysyx_220053_arb_pick.sv
// ysyx_220053_arb_pick: LSU-priority winner select with IFU anti-starvation streak
module ysyx_220053_arb_pick
  import ysyx_220053_pkg::*;
#(
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic if_valid_i,
  input  logic ls_valid_i,
  output logic grant_if_o,
  output logic grant_ls_o
);
  localparam int W = $clog2(MAX_STREAK + 1);
  localparam logic [W-1:0] LIMIT = W'(MAX_STREAK);
  logic [W-1:0] streak_q, streak_d;
  logic ls_win;
  assign ls_win = lsu_wins(ls_valid_i, if_valid_i, streak_q == LIMIT);
  assign grant_ls_o = en_i & ls_win;
  assign grant_if_o = en_i & if_valid_i & !ls_win;
  // streak counts only LSU wins that made a waiting IFU lose
  always_comb begin
    streak_d = grant_if_o ? '0 :
               grant_ls_o ? (if_valid_i ? (streak_q == LIMIT ? streak_q : streak_q + W'(1)) : '0) :
               streak_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) streak_q <= '0;
    else streak_q <= streak_d;
  end
endmodule

// File: rtl/ysyx_220053_mem_arb.sv
// ysyx_220053_mem_arb: shares the single pmem port between IFU fetch and LSU load/store
module ysyx_220053_mem_arb
  import ysyx_220053_pkg::*;
#(
  parameter int unsigned MAX_STREAK   = 4,
  parameter int unsigned TIMEOUT_CYCS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req_valid,
  output logic             if_req_ready,
  input  logic [XLEN-1:0]  if_req_addr,
  output logic             if_rsp_valid,
  output logic [XLEN-1:0]  if_rsp_data,
  output logic             if_rsp_err,
  input  logic             ls_req_valid,
  output logic             ls_req_ready,
  input  logic [XLEN-1:0]  ls_req_addr,
  input  logic             ls_req_wen,
  input  logic [XLEN-1:0]  ls_req_wdata,
  input  logic [MASKW-1:0] ls_req_wmask,
  output logic             ls_rsp_valid,
  output logic [XLEN-1:0]  ls_rsp_rdata,
  output logic             ls_rsp_err,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [XLEN-1:0]  mem_req_addr,
  output logic             mem_req_wen,
  output logic [XLEN-1:0]  mem_req_wdata,
  output logic [MASKW-1:0] mem_req_wmask,
  input  logic             mem_rsp_valid,
  input  logic [XLEN-1:0]  mem_rsp_rdata,
  output logic             busy
);
  arb_state_t state_q;
  logic owner_q, wen_q, err_q, idle, grant_if, grant_ls;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
  logic [MASKW-1:0] wmask_q;
  logic [31:0] cnt_q;
  assign idle = rst & (state_q == IDLE);
  ysyx_220053_arb_pick #(.MAX_STREAK(MAX_STREAK)) u_pick (
    .clk(clk), .rst(rst), .en_i(idle),
    .if_valid_i(if_req_valid), .ls_valid_i(ls_req_valid),
    .grant_if_o(grant_if), .grant_ls_o(grant_ls)
  );
  assign if_req_ready  = grant_if;
  assign ls_req_ready  = grant_ls;
  assign busy          = state_q != IDLE;
  assign mem_req_valid = state_q == REQ;
  assign mem_req_addr  = addr_q;
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wmask = wmask_q;
  assign if_rsp_valid  = (state_q == DONE) & (owner_q == OWNER_IFU);
  assign ls_rsp_valid  = (state_q == DONE) & (owner_q == OWNER_LSU);
  assign if_rsp_data   = if_rsp_valid ? rdata_q : '0;
  assign ls_rsp_rdata  = ls_rsp_valid ? rdata_q : '0;
  assign if_rsp_err    = if_rsp_valid & err_q;
  assign ls_rsp_err    = ls_rsp_valid & err_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= OWNER_IFU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (grant_ls | grant_if) begin
          state_q <= REQ;
          owner_q <= grant_ls ? OWNER_LSU : OWNER_IFU;
          addr_q  <= grant_ls ? ls_req_addr : if_req_addr;
          wen_q   <= grant_ls & ls_req_wen;
          wdata_q <= grant_ls ? ls_req_wdata : '0;
          wmask_q <= grant_ls ? ls_req_wmask : '0;
        end
        REQ: if (mem_req_ready) begin
          state_q <= RESP;
          cnt_q   <= '0;
        end
        // a response in the handshake cycle is never seen here: it arrives while still in REQ
        RESP: if (mem_rsp_valid) begin
          state_q <= DONE;
          rdata_q <= wen_q ? '0 : mem_rsp_rdata;
          err_q   <= 1'b0;
        end else if (TIMEOUT_CYCS != 0 && cnt_q + 32'd1 == TIMEOUT_CYCS) begin
          state_q <= DONE;
          rdata_q <= '0;
          err_q   <= 1'b1;
        end else cnt_q <= cnt_q + 32'd1;
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_220053_mem_arb.sv
// tb_ysyx_220053_mem_arb: directed vector table plus hand sequences for the pmem arbiter
module tb_ysyx_220053_mem_arb;
  logic clk = 1'b0, rst;
  logic if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err;
  logic [63:0] if_req_addr, if_rsp_data;
  logic ls_req_valid, ls_req_ready, ls_req_wen, ls_rsp_valid, ls_rsp_err;
  logic [63:0] ls_req_addr, ls_req_wdata, ls_rsp_rdata;
  logic [7:0] ls_req_wmask;
  logic mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid, busy;
  logic [63:0] mem_req_addr, mem_req_wdata, mem_rsp_rdata;
  logic [7:0] mem_req_wmask;
  int total = 0, bad = 0;

  ysyx_220053_mem_arb #(.MAX_STREAK(4), .TIMEOUT_CYCS(8)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
    .ls_req_wen(ls_req_wen), .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_rdata(ls_rsp_rdata), .ls_rsp_err(ls_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ifv, lsv;
    logic [63:0] ia, la;
    logic wen;
    logic [63:0] wd;
    logic [7:0] wm;
    logic [63:0] rd;
    logic exp_ls;
    logic [63:0] ea;
    logic ew;
    logic [63:0] ewd;
    logic [7:0] ewm;
    logic [63:0] erd;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // called at the negedge of an IDLE cycle with requests already driven; zero-wait memory
  task automatic xact(input string tag, input logic exp_ls, input logic [63:0] ea, input logic ew,
                      input logic [63:0] ewd, input logic [7:0] ewm, input logic [63:0] rd,
                      input logic [63:0] erd);
    #1;
    chk({tag, ".ls_ready"}, ls_req_ready, exp_ls);
    chk({tag, ".if_ready"}, if_req_ready, !exp_ls);
    @(negedge clk);
    #1;
    chk({tag, ".req_valid"}, mem_req_valid, 1);
    chk({tag, ".req_addr"}, mem_req_addr, ea);
    chk({tag, ".req_wen"}, mem_req_wen, ew);
    chk({tag, ".req_wdata"}, mem_req_wdata, ewd);
    chk({tag, ".req_wmask"}, mem_req_wmask, ewm);
    @(negedge clk);
    chk({tag, ".resp_req_low"}, mem_req_valid, 0);
    mem_rsp_valid = 1;
    mem_rsp_rdata = rd;
    @(negedge clk);
    mem_rsp_valid = 0;
    #1;
    chk({tag, ".own_rsp"}, exp_ls ? ls_rsp_valid : if_rsp_valid, 1);
    chk({tag, ".other_rsp"}, exp_ls ? if_rsp_valid : ls_rsp_valid, 0);
    chk({tag, ".rsp_data"}, exp_ls ? ls_rsp_rdata : if_rsp_data, erd);
    chk({tag, ".rsp_err"}, exp_ls ? ls_rsp_err : if_rsp_err, 0);
    @(negedge clk);
    chk({tag, ".idle_busy"}, busy, 0);
  endtask

  initial begin
    int k;
    logic got;
    vecs[0] = '{1, 0, 64'h8000_0000, 64'h1234, 1, 64'hFF, 8'hFF, 64'h13,
                0, 64'h8000_0000, 0, 64'h0, 8'h00, 64'h13};
    vecs[1] = '{1, 1, 64'h8000_0004, 64'h8000_0100, 1, 64'hAA, 8'h01, 64'hDEAD,
                1, 64'h8000_0100, 1, 64'hAA, 8'h01, 64'h0};
    vecs[2] = '{0, 1, 64'h0, 64'h8000_0200, 0, 64'h55, 8'h0F, 64'h1122_3344_5566_7788,
                1, 64'h8000_0200, 0, 64'h55, 8'h0F, 64'h1122_3344_5566_7788};
    vecs[3] = '{1, 0, 64'h8000_0008, 64'h0, 0, 64'h0, 8'h00, 64'hCAFE_BABE_0000_0001,
                0, 64'h8000_0008, 0, 64'h0, 8'h00, 64'hCAFE_BABE_0000_0001};
    rst = 0;
    if_req_valid = 1; ls_req_valid = 1;
    if_req_addr = '0; ls_req_addr = '0; ls_req_wen = 0; ls_req_wdata = '0; ls_req_wmask = '0;
    mem_req_ready = 1; mem_rsp_valid = 0; mem_rsp_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.if_ready", if_req_ready, 0);
    chk("rst.ls_ready", ls_req_ready, 0);
    chk("rst.mem_req_valid", mem_req_valid, 0);
    chk("rst.mem_req_addr", mem_req_addr, 0);
    chk("rst.rsp_valids", {if_rsp_valid, ls_rsp_valid}, 0);
    if_req_valid = 0; ls_req_valid = 0; rst = 1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if_req_valid = vecs[i].ifv; ls_req_valid = vecs[i].lsv;
      if_req_addr = vecs[i].ia; ls_req_addr = vecs[i].la; ls_req_wen = vecs[i].wen;
      ls_req_wdata = vecs[i].wd; ls_req_wmask = vecs[i].wm;
      xact($sformatf("vec%0d", i), vecs[i].exp_ls, vecs[i].ea, vecs[i].ew, vecs[i].ewd,
           vecs[i].ewm, vecs[i].rd, vecs[i].erd);
    end
    if_req_valid = 0; ls_req_valid = 0;
    // both requesters held: four LSU wins, then IFU, then LSU again after the streak resets
    if_req_addr = 64'h8000_1000; ls_req_addr = 64'h8000_2000;
    ls_req_wen = 0; ls_req_wdata = '0; ls_req_wmask = '0;
    if_req_valid = 1; ls_req_valid = 1;
    for (int g = 0; g < 6; g++)
      xact($sformatf("streak%0d", g), g != 4, g != 4 ? 64'h8000_2000 : 64'h8000_1000,
           0, 0, 0, 64'(g + 1), 64'(g + 1));
    if_req_valid = 0; ls_req_valid = 0;
    // memory stalls the request for five cycles
    if_req_valid = 1; if_req_addr = 64'h8000_3000;
    #1 chk("stall.if_ready", if_req_ready, 1);
    @(negedge clk);
    if_req_valid = 0; if_req_addr = 64'hBAD; ls_req_valid = 1; ls_req_addr = 64'h8000_4000;
    for (int s = 0; s < 6; s++) begin
      mem_req_ready = (s == 5);
      #1;
      chk($sformatf("stall%0d.valid", s), mem_req_valid, 1);
      chk($sformatf("stall%0d.addr", s), mem_req_addr, 64'h8000_3000);
      chk($sformatf("stall%0d.wdata", s), mem_req_wdata, 0);
      chk($sformatf("stall%0d.ls_ready", s), ls_req_ready, 0);
      @(negedge clk);
    end
    ls_req_valid = 0;
    chk("stall.resp_req_low", mem_req_valid, 0);
    mem_rsp_valid = 1; mem_rsp_rdata = 64'h77;
    @(negedge clk);
    mem_rsp_valid = 0;
    #1;
    chk("stall.if_rsp", if_rsp_valid, 1);
    chk("stall.if_data", if_rsp_data, 64'h77);
    @(negedge clk);
    chk("stall.idle", busy, 0);
    // memory never answers: timeout after 8 cycles in RESP
    ls_req_valid = 1; ls_req_addr = 64'h8000_5000; ls_req_wen = 0; mem_rsp_rdata = 64'hFFFF;
    #1 chk("tmo.ls_ready", ls_req_ready, 1);
    k = 0; got = 0;
    while (k < 30 && !got) begin
      @(negedge clk);
      ls_req_valid = 0;
      k++;
      #1 got = ls_rsp_valid;
    end
    chk("tmo.latency", 64'(k), 64'd10);
    chk("tmo.err", ls_rsp_err, 1);
    chk("tmo.rdata", ls_rsp_rdata, 0);
    chk("tmo.if_rsp", if_rsp_valid, 0);
    @(negedge clk);
    chk("tmo.idle", busy, 0);
    // reset during RESP, then a stray response
    ls_req_valid = 1; ls_req_addr = 64'h8000_6000;
    #1 chk("rstmid.ls_ready", ls_req_ready, 1);
    @(negedge clk);
    ls_req_valid = 0;
    @(negedge clk);
    chk("rstmid.busy_resp", busy, 1);
    rst = 0;
    @(negedge clk);
    if_req_valid = 1;
    #1;
    chk("rstmid.busy", busy, 0);
    chk("rstmid.if_ready", if_req_ready, 0);
    chk("rstmid.addr", mem_req_addr, 0);
    rst = 1; if_req_valid = 0; mem_rsp_valid = 1; mem_rsp_rdata = 64'h99;
    @(negedge clk);
    mem_rsp_valid = 0;
    #1;
    chk("stray.rsp", {if_rsp_valid, ls_rsp_valid}, 0);
    chk("stray.busy", busy, 0);
    @(negedge clk);
    chk("stray.rsp2", {if_rsp_valid, ls_rsp_valid}, 0);
    if_req_valid = 1; if_req_addr = 64'h8000_7000;
    xact("post_rst", 0, 64'h8000_7000, 0, 0, 0, 64'h42, 64'h42);
    if_req_valid = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
